// File: rtl/order_content_pkg.sv
// Shared types and helpers for the order-content dual-port RAM.
package order_content_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RL_SHORT  = 1;
  localparam int RL_LONG   = 2;
  localparam int PAR_MAX_W = 1024;

  // Callers zero-extend their data to PAR_MAX_W; padding does not change parity.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/order_content_port_pipe.sv
// Per-port read return pipeline: bypass select, optional parity check, and
// an extra output register when READ_LATENCY is 2. Parity check: ORDER_CONTENT_PARITY_EN.
module order_content_port_pipe
  import order_content_pkg::*;
#(
  parameter int DATA_WIDTH   = 217,
  parameter int MEM_W        = 217,
  parameter int READ_LATENCY = RL_SHORT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic                  peer_hit_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [DATA_WIDTH-1:0] peer_din_i,
  input  logic [MEM_W-1:0]      rd_word_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o,
  output logic                  parity_err_o
);

  logic                  vld_p0;
  logic                  byp_p0;
  logic [DATA_WIDTH-1:0] byp_data_p0;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  par_bad;

  // Stage p0: aligned with the registered array read in the top
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= req_i;
  end

  always_ff @(posedge clk) begin
    if (req_i) begin
      byp_p0      <= we_i | peer_hit_i;
      byp_data_p0 <= we_i ? din_i : peer_din_i;
    end
  end

  assign sel_data = byp_p0 ? byp_data_p0 : rd_word_i[DATA_WIDTH-1:0];

`ifdef ORDER_CONTENT_PARITY_EN
  assign par_bad = vld_p0 & ~byp_p0 &
                   (rd_word_i[DATA_WIDTH] !=
                    even_parity({{(PAR_MAX_W-DATA_WIDTH){1'b0}}, rd_word_i[DATA_WIDTH-1:0]}));
`else
  assign par_bad = 1'b0;
`endif

  generate
    if (READ_LATENCY == RL_LONG) begin : g_lat2
      logic                  vld_p1;
      logic                  err_p1;
      logic [DATA_WIDTH-1:0] dout_p1;

      // Stage p1: output register
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          err_p1  <= 1'b0;
          dout_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          err_p1 <= par_bad;
          if (vld_p0) dout_p1 <= sel_data;
        end
      end

      assign dout_o       = dout_p1;
      assign valid_o      = vld_p1;
      assign parity_err_o = err_p1;
    end else begin : g_lat1
      logic [DATA_WIDTH-1:0] hold_q;

      always_ff @(posedge clk) begin
        if (reset)       hold_q <= '0;
        else if (vld_p0) hold_q <= sel_data;
      end

      assign dout_o       = vld_p0 ? sel_data : hold_q;
      assign valid_o      = vld_p0;
      assign parity_err_o = par_bad;
    end
  endgenerate

endmodule

// File: rtl/order_content_dp_ram.sv
// True dual-port order-content RAM with post-reset clear engine.
// Optional stored even parity: ORDER_CONTENT_PARITY_EN.
module order_content_dp_ram
  import order_content_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 217,
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    READ_LATENCY = RL_SHORT,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic [1:0]            parity_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef ORDER_CONTENT_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef ORDER_CONTENT_PARITY_EN
    return {even_parity({{(PAR_MAX_W-DATA_WIDTH){1'b0}}, d}), d};
`else
    return d;
`endif
  endfunction

  (* ram_style = "block" *) logic [MEM_W-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clearing, ready;
  logic                  a_acc, b_acc, a_wr, b_wr, addr_eq;
  logic                  wa_en, wb_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [MEM_W-1:0]      wa_data;
  logic [MEM_W-1:0]      rd_a_q, rd_b_q;
  logic                  err_a, err_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
    end
  end

  assign clearing  = (state_q == ST_CLEAR);
  assign init_busy = clearing;
  assign ready     = (state_q == ST_READY) & ~reset;
  assign a_acc     = a_en & ready;
  assign b_acc     = b_en & ready;
  assign a_wr      = a_acc & a_we;
  assign b_wr      = b_acc & b_we;
  assign addr_eq   = (a_addr == b_addr);

  // The clear engine borrows port A; A wins a same-address write collision.
  assign wa_en   = clearing | a_wr;
  assign wa_addr = clearing ? clr_addr_q : a_addr;
  assign wa_data = clearing ? encode(INIT_VALUE) : encode(a_din);
  assign wb_en   = b_wr & ~(a_wr & addr_eq);

  always_ff @(posedge clk) begin
    if (wa_en) mem_q[wa_addr] <= wa_data;
    if (wb_en) mem_q[b_addr]  <= encode(b_din);
    if (a_acc) rd_a_q <= mem_q[a_addr];
    if (b_acc) rd_b_q <= mem_q[b_addr];
  end

  order_content_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEM_W       (MEM_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk         (clk),
    .reset       (reset),
    .req_i       (a_acc),
    .we_i        (a_we),
    .peer_hit_i  (b_wr & addr_eq),
    .din_i       (a_din),
    .peer_din_i  (b_din),
    .rd_word_i   (rd_a_q),
    .dout_o      (a_dout),
    .valid_o     (a_valid),
    .parity_err_o(err_a)
  );

  order_content_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEM_W       (MEM_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk         (clk),
    .reset       (reset),
    .req_i       (b_acc),
    .we_i        (b_we),
    .peer_hit_i  (a_wr & addr_eq),
    .din_i       (b_din),
    .peer_din_i  (a_din),
    .rd_word_i   (rd_b_q),
    .dout_o      (b_dout),
    .valid_o     (b_valid),
    .parity_err_o(err_b)
  );

  assign parity_err = {err_b, err_a};

endmodule

// File: tb/tb_order_content_dp_ram.sv
// Directed bench: one latency-1 instance and one latency-2 instance share stimulus.
module tb_order_content_dp_ram;

  localparam int DW = 217;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          init_busy, a_valid, b_valid;
  logic [DW-1:0] a_dout, b_dout;
  logic [1:0]    parity_err;

  logic          init_busy2, a_valid2, b_valid2;
  logic [DW-1:0] a_dout2, b_dout2;
  logic [1:0]    parity_err2;

  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 clk = ~clk;

  order_content_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid),
    .parity_err(parity_err)
  );

  order_content_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .init_busy(init_busy2),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout2), .a_valid(a_valid2),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout2), .b_valid(b_valid2),
    .parity_err(parity_err2)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_en = en; a_we = we; a_addr = addr; a_din = din;
  endtask

  task automatic drive_b(input logic en, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    b_en = en; b_we = we; b_addr = addr; b_din = din;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    check_val("rst_busy",    DW'(init_busy),  1);
    check_val("rst_a_valid", DW'(a_valid),    0);
    check_val("rst_b_valid", DW'(b_valid),    0);
    check_val("rst_a_dout",  a_dout,          0);
    check_val("rst_b_dout",  b_dout,          0);
    check_val("rst_parity",  DW'(parity_err), 0);

    // Clear length, with a write issued late in the clear that must be dropped
    reset = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 4090) drive_a(1'b1, 1'b1, 12'h005, 'h1F);
      if (cnt == 4091) begin
        check_val("drop_valid", DW'(a_valid), 0);
        idle();
      end
    end while (init_busy === 1'b1 && cnt < 5000);
    check_val("clear_len",  DW'(cnt),        4096);
    check_val("clear_len2", DW'(init_busy2), 0);

    // Write/write collision: A's data stored, each port returns own din
    drive_a(1'b1, 1'b1, 12'h010, 'hABC);
    drive_b(1'b1, 1'b1, 12'h010, 'h123);
    step();
    check_val("ww_a_dout",   a_dout,        'hABC);
    check_val("ww_a_valid",  DW'(a_valid),  1);
    check_val("ww_b_dout",   b_dout,        'h123);
    check_val("ww_b_valid",  DW'(b_valid),  1);
    check_val("rl2_early",   DW'(b_valid2), 0);

    // Both read same address
    drive_a(1'b1, 1'b0, 12'h010, '0);
    drive_b(1'b1, 1'b0, 12'h010, '0);
    step();
    check_val("rr_a_dout",  a_dout,          'hABC);
    check_val("rr_b_dout",  b_dout,          'hABC);
    check_val("par_clean",  DW'(parity_err), 0);
    check_val("rl2_ww_a",   a_dout2,         'hABC);
    check_val("rl2_ww_b",   b_dout2,         'h123);

    // A write, B read bypass
    drive_a(1'b1, 1'b1, 12'h020, 'h55);
    drive_b(1'b1, 1'b0, 12'h020, '0);
    step();
    check_val("wr_b_byp",  b_dout,  'h55);
    check_val("wr_a_own",  a_dout,  'h55);
    check_val("rl2_rr_b",  b_dout2, 'hABC);

    // B write, A read bypass
    drive_a(1'b1, 1'b0, 12'h030, '0);
    drive_b(1'b1, 1'b1, 12'h030, 'h66);
    step();
    check_val("rw_a_byp",   a_dout,        'h66);
    check_val("rw_b_own",   b_dout,        'h66);
    check_val("rl2_byp_b",  b_dout2,       'h55);
    check_val("rl2_byp_v",  DW'(b_valid2), 1);

    // Independent addresses, then cross-read next cycle
    drive_a(1'b1, 1'b1, 12'h040, 'h111);
    drive_b(1'b1, 1'b1, 12'h041, 'h222);
    step();
    check_val("ind_a", a_dout, 'h111);
    check_val("ind_b", b_dout, 'h222);
    drive_a(1'b1, 1'b0, 12'h041, '0);
    drive_b(1'b1, 1'b0, 12'h040, '0);
    step();
    check_val("xrd_a", a_dout, 'h222);
    check_val("xrd_b", b_dout, 'h111);

    // Idle: valid drops, dout holds
    idle();
    step();
    check_val("hold_a_valid", DW'(a_valid),  0);
    check_val("hold_b_valid", DW'(b_valid),  0);
    check_val("hold_a_dout",  a_dout,        'h222);
    check_val("rl2_xrd_a",    a_dout2,       'h222);
    check_val("rl2_xrd_v",    DW'(a_valid2), 1);
    step();
    check_val("rl2_hold_v",   DW'(a_valid2), 0);
    check_val("rl2_hold_d",   a_dout2,       'h222);

    // Dropped write left addr 5 cleared; clear-zero reads
    drive_a(1'b1, 1'b0, 12'h005, '0);
    step();
    check_val("rd5_dout",  a_dout,       0);
    check_val("rd5_valid", DW'(a_valid), 1);
    drive_a(1'b1, 1'b0, 12'h000, '0);
    step();
    check_val("rd0", a_dout, 0);
    drive_a(1'b1, 1'b0, 12'hFFF, '0);
    step();
    check_val("rdFFF", a_dout, 0);
    drive_a(1'b1, 1'b0, 12'h7A5, '0);
    step();
    check_val("rd7A5", a_dout, 0);
    drive_a(1'b1, 1'b0, 12'h010, '0);
    step();
    check_val("rd010", a_dout, 'hABC);
    idle();

`ifdef ORDER_CONTENT_PARITY_EN
    dut.mem_q[3][0] = ~dut.mem_q[3][0];
    drive_b(1'b1, 1'b0, 12'h003, '0);
    drive_a(1'b1, 1'b0, 12'h004, '0);
    step();
    check_val("par_err_b", DW'(parity_err), 2);
    check_val("par_b_vld", DW'(b_valid),    1);
    idle();
    step();
    check_val("par_idle",  DW'(parity_err), 0);
`endif

    // Reset during clear restarts from address 0
    reset = 1'b1;
    step();
    check_val("mid_rst_dout", a_dout, 0);
    reset = 1'b0;
    repeat (1000) step();
    reset = 1'b1;
    step();
    check_val("mid_rst_busy",  DW'(init_busy), 1);
    check_val("mid_rst_valid", DW'(a_valid),   0);
    reset = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (init_busy === 1'b1 && cnt < 5000);
    check_val("reclear_len", DW'(cnt), 4096);
    drive_a(1'b1, 1'b0, 12'h010, '0);
    step();
    check_val("reclear_rd", a_dout, 0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
